// File: rtl/eeprom_arbiter.sv
// -----------------------------------------------------------------------------
// eeprom_arbiter
//
// Two-port round-robin arbiter and sequencer in front of the EEPROM I2C
// read/write engine. Each requester posts a single byte read or write and
// holds it until its done pulse. The arbiter serialises these requests onto
// the engine's WR/RD/ADDR/DATA/ACK handshake and returns completion and read
// data per port. After every write it waits out the EEPROM internal
// write-cycle time before it issues anything else.
//
// Parameters
//   TWR_CYC  idle cycles after a completed write before the next grant
//            (0 disables the gap)
//   CNT_W    width of the write-gap counter; must be able to hold TWR_CYC
//
// Ports
//   CLK             clock; all logic runs on its rising edge
//   rst             asynchronous, active-low reset
//   req0/req1       request; held with the command fields stable until done
//   we0/we1         1 = write, 0 = read
//   addr0/addr1     EEPROM byte address
//   wdata0/wdata1   write data
//   gnt0/gnt1       high from issue until done, inclusive
//   done0/done1     one-cycle completion pulse
//   rdata0/rdata1   read result; valid with done, held until the next read
//   busy            high in every state except IDLE
//   WR/RD           one-cycle start strobes to the engine
//   ADDR            address to the engine
//   DATA            write data during a write, high impedance otherwise
//   ACK             one-cycle engine completion pulse
// -----------------------------------------------------------------------------
module eeprom_arbiter #(
  parameter int TWR_CYC = 250000,
  parameter int CNT_W   = 18
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [10:0] addr0,
  input  logic [10:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        busy,
  output logic        WR,
  output logic        RD,
  output logic [10:0] ADDR,
  inout  wire  [7:0]  DATA,
  input  logic        ACK
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_DONE,
    S_GAP
  } state_t;

  // The gap counter is loaded with TWR_CYC-1 so that GAP lasts exactly
  // TWR_CYC cycles. The load value is clamped so it stays legal when the
  // gap is disabled.
  localparam bit               GAP_EN   = (TWR_CYC > 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_EN ? TWR_CYC - 1 : 0);

  state_t           state_q;
  state_t           state_d;
  logic             ptr_q;       // port that wins when both requests are pending
  logic             sel_q;       // port owning the current transaction
  logic             we_q;
  logic [10:0]      addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata0_q;
  logic [7:0]       rdata1_q;
  logic [CNT_W-1:0] gap_cnt_q;

  logic             any_req;
  logic             win_sel;
  logic             grant;
  logic             data_oe;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone request wins outright. When both ports are pending,
  // the pointer decides.
  // ---------------------------------------------------------------------------
  assign any_req = req0 | req1;
  assign win_sel = (req0 && req1) ? ptr_q : req1;
  assign grant   = (state_q == S_IDLE) && any_req;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst) begin
    // NOTE: clocked state is always updated with non-blocking assignments, so
    // every flop samples values from before the edge, whatever order the
    // processes run in.
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: give state_d a default before the case, so that every path through
    // the process assigns it and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (any_req) state_d = S_ISSUE;
      S_ISSUE:    state_d = S_WAIT_ACK;
      // No timeout: the engine is trusted to finish every transaction.
      S_WAIT_ACK: if (ACK) state_d = S_DONE;
      S_DONE:     state_d = (we_q && GAP_EN) ? S_GAP : S_IDLE;
      S_GAP:      if (gap_cnt_q == '0) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: command latch, round-robin pointer, read capture, gap counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ptr_q     <= 1'b0;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      if (grant) begin
        sel_q   <= win_sel;
        we_q    <= win_sel ? we1    : we0;
        addr_q  <= win_sel ? addr1  : addr0;
        wdata_q <= win_sel ? wdata1 : wdata0;
        ptr_q   <= ~ptr_q;
      end

      // Read data is valid on the bus on the same edge that ACK is sampled.
      // Only the owning port's register is loaded.
      if ((state_q == S_WAIT_ACK) && ACK && !we_q) begin
        if (sel_q) begin
          rdata1_q <= DATA;
        end else begin
          rdata0_q <= DATA;
        end
      end

      if ((state_q == S_DONE) && we_q && GAP_EN) begin
        gap_cnt_q <= GAP_LOAD;
      end else if ((state_q == S_GAP) && (gap_cnt_q != '0)) begin
        gap_cnt_q <= gap_cnt_q - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    WR      = 1'b0;
    RD      = 1'b0;
    busy    = 1'b1;
    data_oe = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_ISSUE: begin
        gnt0    = ~sel_q;
        gnt1    = sel_q;
        WR      = we_q;
        RD      = ~we_q;
        data_oe = we_q;
      end
      S_WAIT_ACK: begin
        gnt0    = ~sel_q;
        gnt1    = sel_q;
        data_oe = we_q;
      end
      S_DONE: begin
        // The grant stays up through the done pulse. DATA is already
        // released here, so the engine sees an undriven bus before IDLE.
        gnt0  = ~sel_q;
        gnt1  = sel_q;
        done0 = ~sel_q;
        done1 = sel_q;
      end
      S_GAP: begin
        // Only busy stays high while the EEPROM completes its write cycle.
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign ADDR   = addr_q;
  assign DATA   = data_oe ? wdata_q : 8'hzz;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: doc/eeprom_arbiter.md
# eeprom_arbiter

Two-port round-robin arbiter and sequencer in front of the EEPROM I2C read/write engine. It accepts independent byte read/write requests from two requesters, serializes them onto the engine's level-sensitive WR/RD/ADDR/DATA/ACK interface, and returns completion and read data per requester. After every write it enforces the EEPROM internal write-cycle time before the next transaction is issued.

## Interface
- TWR_CYC, 250000: idle cycles after a completed write before the next grant; 5 ms at 50 MHz; 0 disables the gap.
- CNT_W, 18: width of the write-gap counter; must hold TWR_CYC.
- CLK  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0, req1  in  1  request; held high with cmd fields stable until the matching done.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  11  EEPROM byte address.
- wdata0, wdata1  in  8  write data.
- gnt0, gnt1  out  1  high from issue until done, inclusive.
- done0, done1  out  1  one-cycle completion pulse.
- rdata0, rdata1  out  8  read result; valid with done, held until that port's next read completes.
- busy  out  1  high in every state except IDLE.
- WR, RD  out  1  one-cycle start strobes to the engine.
- ADDR  out  11  address to the engine.
- DATA  inout  8  driven with write data during a write; hi-Z otherwise.
- ACK  in  1  engine completion pulse, one cycle.

## Operation
- Reset values: WR=RD=0, ADDR=0, DATA hi-Z, gnt*=0, done*=0, rdata*=0, busy=0, state=IDLE, round-robin pointer=0, gap counter=0.
- IDLE: samples req0/req1.
  - One request pending: that port wins.
  - Both pending: the port named by the pointer wins.
  - On a grant, go to ISSUE. Latch sel, we, addr and wdata. Drive ADDR from the latched address. Drive DATA from the latched data when we=1. Set gnt[sel].
  - Pointer toggles to the other port on every grant.
- ISSUE, 1 cycle: WR=1 if we, else RD=1; then go to WAIT_ACK.
- WAIT_ACK: WR=RD=0. ADDR, DATA and gnt held. No time limit.
  - On ACK=1, go to DONE.
  - For a read, capture DATA into rdata[sel] on that same edge.
- DONE, 1 cycle: done[sel]=1 and gnt[sel] stays 1. Release DATA to hi-Z.
  - Write with TWR_CYC>0: go to GAP and load the counter with TWR_CYC-1.
  - Otherwise go to IDLE.
- GAP: gnt=0, busy=1. Counter decrements each cycle; at 0 go to IDLE. Requests arriving meanwhile wait.
- Requester rule: drop req on the edge at which done is seen. A req still high in IDLE is treated as a new transaction.
- ACK outside WAIT_ACK is ignored.
- rdata of the non-selected port never changes. A write never changes rdata.
- rst low at any time forces reset values immediately, including mid-transaction and mid-gap. The engine is reset by the same top-level reset.

## Timing
- Edge e0: IDLE sees req. ISSUE spans e0–e1 with WR/RD high. WAIT_ACK starts at e1.
- ACK sampled at edge ea. done is high in cycle ea–ea+1.
- Read: earliest next grant edge is ea+2, which guarantees WR/RD is low while the engine passes through its idle state.
- Write: earliest next grant edge is ea+1+TWR_CYC+1.
- Arbitration adds 1 cycle of latency from req to strobe.
- No back-to-back grants to the same port without passing through IDLE.

## Test plan
- Single write, TWR_CYC=4: port0 req, we=1, addr=0x1A5, wdata=0x3C.
  - Expect a WR pulse of exactly 1 cycle, ADDR=0x1A5 and DATA=0x3C held until ACK, done0 pulse.
  - busy stays high 4 further cycles; a req1 raised in that window is granted only afterwards.
- Single read: port1 req, we=0, addr=0x7FF; engine model returns 0xA7 with ACK.
  - Expect an RD pulse, DATA hi-Z from the arbiter throughout, done1 pulse, rdata1=0xA7, rdata0 unchanged at 0.
- Simultaneous requests after reset (pointer=0), both reads:
  - Grant order is port0 then port1.
  - A second simultaneous pair is granted port0 then port1 again, because the pointer has toggled twice.
- Requester holds req one cycle past done:
  - A second WR/RD issues for the same port, confirming the new-transaction rule.
  - Compliant drop produces no extra strobe.
- Reset mid-WAIT_ACK and mid-GAP: rst low for 1 cycle.
  - All outputs return to reset values within the reset cycle, DATA goes hi-Z, pointer returns to 0.
  - A later ACK while in IDLE produces no done.
- Stray ACK in IDLE and in GAP: no done, no state change, rdata untouched.
